icache_direct: RTL and testbench



---
 rtl/cpu_types_pkg.sv | 36 +++
 rtl/icache_direct.sv | 140 ++++++++++++++
 tb/tb_icache_direct.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_types_pkg
//  Purpose  : Shared types for the direct-mapped instruction cache.
//             The widths and structs describe the default geometry
//             (16 one-word frames, 32-bit words). The cache module takes
//             its widths from its own parameters, so other geometries work.
//  Contents : ICACHE_IDX_W, ICACHE_TAG_W, icachef_t, icache_state_t,
//             icache_frame_t
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

    localparam int ICACHE_IDX_W = 4;
    localparam int ICACHE_TAG_W = 32 - ICACHE_IDX_W - 2;

    // Fetch address as seen by the cache: tag | frame index | byte offset
    typedef struct packed {
        logic [ICACHE_TAG_W-1:0] tag;
        logic [ICACHE_IDX_W-1:0] idx;
        logic [1:0]              bytoff;
    } icachef_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MISS = 1'b1
    } icache_state_t;

    typedef struct packed {
        logic                    valid;
        logic [ICACHE_TAG_W-1:0] tag;
        logic [31:0]             data;
    } icache_frame_t;

endpackage : cpu_types_pkg
`default_nettype wire

// File: rtl/icache_direct.sv
`default_nettype none
// ============================================================================
//  Module   : icache_direct
//  Purpose  : Direct-mapped, read-only instruction cache with one-word
//             frames. Hits are served combinationally in the same cycle;
//             a miss stalls the fetch, issues one word read to memory,
//             fills the frame and then hits.
//  Ports    : CLK, nRST                  - clock, async active-low reset
//             imemREN, imemaddr          - datapath fetch request/address
//             ihit, imemload             - fetch satisfied / instruction
//             iREN, iaddr                - memory read request/address
//             iwait, iload               - memory busy / read data
//             hit_count, miss_count      - only with ICACHE_STATS_EN
//  Options  : ICACHE_STATS_EN - adds free-running hit and miss counters
//  Revision : 1.0 - initial release
// ============================================================================
module icache_direct
    import cpu_types_pkg::*;
#(
    parameter int ICACHE_FRAMES = 16,
    parameter int WORD_W        = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              imemREN,
    input  logic [WORD_W-1:0] imemaddr,
    output logic              ihit,
    output logic [WORD_W-1:0] imemload,
    output logic              iREN,
    output logic [WORD_W-1:0] iaddr,
    input  logic              iwait,
    input  logic [WORD_W-1:0] iload
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    localparam int c_IDX_W = $clog2(ICACHE_FRAMES);
    localparam int c_TAG_W = WORD_W - c_IDX_W - 2;

    // ------------------------------------------------------------------
    // Frame storage. Only the valid bits need a reset; tag and data are
    // don't-care until a fill sets the valid bit.
    // ------------------------------------------------------------------
    logic [ICACHE_FRAMES-1:0] r_valid;
    logic [c_TAG_W-1:0]       r_tag  [ICACHE_FRAMES];
    logic [WORD_W-1:0]        r_data [ICACHE_FRAMES];

    icache_state_t            r_state;
    logic [WORD_W-3:0]        r_missaddr;

    logic [c_TAG_W-1:0]       w_tag;
    logic [c_IDX_W-1:0]       w_idx;
    logic [c_TAG_W-1:0]       w_miss_tag;
    logic [c_IDX_W-1:0]       w_miss_idx;
    logic                     w_hit;
    logic                     w_start_miss;
    logic                     w_fill;
    logic                     w_unused;

    assign w_tag      = imemaddr[WORD_W-1:c_IDX_W+2];
    assign w_idx      = imemaddr[c_IDX_W+1:2];
    assign w_miss_tag = r_missaddr[WORD_W-3:c_IDX_W];
    assign w_miss_idx = r_missaddr[c_IDX_W-1:0];

    // Byte offset never takes part in the lookup
    assign w_unused   = ^imemaddr[1:0];

    // Lookup is only meaningful in IDLE; during MISS the fetch is stalled
    assign w_hit        = imemREN && (r_state == IDLE) && r_valid[w_idx]
                          && (r_tag[w_idx] == w_tag);
    assign w_start_miss = imemREN && (r_state == IDLE) && !w_hit;
    assign w_fill       = (r_state == MISS) && !iwait;

    // Outputs derive from state so an asynchronous reset drops iREN at once
    assign ihit     = w_hit;
    assign imemload = w_hit ? r_data[w_idx] : '0;
    assign iREN     = (r_state == MISS);
    assign iaddr    = (r_state == MISS) ? {r_missaddr, 2'b00} : '0;

    // ------------------------------------------------------------------
    // Two-state controller: valid bits, miss address and state
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state    <= IDLE;
            r_missaddr <= '0;
            r_valid    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start_miss) begin
                        r_missaddr <= imemaddr[WORD_W-1:2];
                        r_state    <= MISS;
                    end
                end
                MISS: begin
                    // The fill always completes into the captured frame,
                    // whatever the fetch port does in the meantime
                    if (!iwait) begin
                        r_valid[w_miss_idx] <= 1'b1;
                        r_state             <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Tag/data arrays carry no reset so they can map onto plain RAM
    always_ff @(posedge CLK) begin
        if (w_fill) begin
            r_tag[w_miss_idx]  <= w_miss_tag;
            r_data[w_miss_idx] <= iload;
        end
    end

`ifdef ICACHE_STATS_EN
    // ------------------------------------------------------------------
    // Statistics counters, wrapping modulo 2^32
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (w_hit) begin
                hit_count <= hit_count + 32'd1;
            end
            if (w_start_miss) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule : icache_direct
`default_nettype wire

// File: tb/tb_icache_direct.sv
`default_nettype none
// ============================================================================
//  Module   : tb_icache_direct
//  Purpose  : Directed self-checking bench for icache_direct. Expected fetch
//             data is pushed to a scoreboard queue when a fetch is issued
//             and popped when the cache reports a hit. A small memory model
//             answers read requests with a programmable wait count.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_icache_direct;

    logic        CLK      = 1'b0;
    logic        nRST     = 1'b0;
    logic        imemREN  = 1'b0;
    logic [31:0] imemaddr = '0;
    logic        iwait    = 1'b1;
    logic [31:0] iload    = '0;
    logic        ihit;
    logic        iREN;
    logic [31:0] imemload;
    logic [31:0] iaddr;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int          vectors    = 0;
    int          errors     = 0;
    int          exp_hits   = 0;
    int          exp_misses = 0;
    logic [31:0] sb_q [$];

    icache_direct #(
        .ICACHE_FRAMES (16),
        .WORD_W        (32)
    ) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    always #5 CLK = ~CLK;

    // Memory contents: word 0 holds the first-instruction pattern
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        if (a == 32'h0) w = 32'h3C010001;
        else            w = {a[15:0] ^ 16'h5A5A, a[15:0]};
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Issue one fetch, serve memory reads with 'waits' busy cycles and
    // check the hit data against the scoreboard. Entered 1 ns after an edge.
    task automatic fetch(input logic [31:0] a, input int waits, input bit exp_miss);
        int          cyc         = 0;
        int          miss_cycles = 0;
        bit          done        = 0;
        logic [31:0] exp;
        sb_q.push_back(mem_word(a));
        imemREN  = 1'b1;
        imemaddr = a;
        if (exp_miss) exp_misses++;
        while (!done && cyc < 50) begin
            #1;
            if (iREN) begin
                chk("miss_iaddr", iaddr, {a[31:2], 2'b00});
                iwait = (miss_cycles < waits);
                iload = iwait ? 32'hDEADBEEF : mem_word(iaddr);
                miss_cycles++;
            end else begin
                iwait = 1'b1;
                iload = '0;
            end
            #1;
            if (ihit) begin
                exp = sb_q.pop_front();
                chk("hit_data", imemload, exp);
                chk("hit_iren", {31'd0, iREN}, 32'd0);
                exp_hits++;
                done = 1;
            end
            tick();
            cyc++;
        end
        chk("fetch_done", {31'd0, done}, 32'd1);
        chk("miss_cycles", miss_cycles, exp_miss ? waits + 1 : 0);
        imemREN = 1'b0;
        iwait   = 1'b1;
        iload   = '0;
    endtask

    initial begin
        logic [31:0] exp;

        // ---- reset state
        #12;
        chk("rst_ihit", {31'd0, ihit}, 32'd0);
        chk("rst_iren", {31'd0, iREN}, 32'd0);
        chk("rst_iaddr", iaddr, 32'd0);
        chk("rst_imemload", imemload, 32'd0);
        tick();
        nRST = 1'b1;
        tick();

        // ---- cold miss with 3 wait cycles, then the repeat fetch hits
        fetch(32'h0000_0000, 3, 1);
        fetch(32'h0000_0000, 0, 0);
`ifdef ICACHE_STATS_EN
        chk("stat_hits_a", hit_count, exp_hits);
        chk("stat_miss_a", miss_count, exp_misses);
`endif

        // ---- conflicting frames share index 1
        fetch(32'h0000_0004, 0, 1);
        fetch(32'h0000_0004, 0, 0);
        fetch(32'h0000_0044, 2, 1);
        fetch(32'h0000_0044, 0, 0);
        fetch(32'h0000_0004, 1, 1);

        // ---- fetch address changes from 0x8 to 0xC during the miss
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0008;
        #2;
        chk("mm_ihit0", {31'd0, ihit}, 32'd0);
        tick();
        exp_misses++;
        chk("mm_iren", {31'd0, iREN}, 32'd1);
        chk("mm_iaddr8", iaddr, 32'h0000_0008);
        imemaddr = 32'h0000_000C;
        iwait    = 1'b0;
        iload    = mem_word(32'h0000_0008);
        #1;
        chk("mm_iaddr_hold", iaddr, 32'h0000_0008);
        chk("mm_ihit1", {31'd0, ihit}, 32'd0);
        tick();
        iwait = 1'b1;
        iload = '0;
        #1;
        chk("mm_c_miss", {31'd0, ihit}, 32'd0);
        tick();
        exp_misses++;
        sb_q.push_back(mem_word(32'h0000_000C));
        chk("mm_c_iren", {31'd0, iREN}, 32'd1);
        chk("mm_c_iaddr", iaddr, 32'h0000_000C);
        iwait = 1'b0;
        iload = mem_word(32'h0000_000C);
        tick();
        iwait = 1'b1;
        iload = '0;
        #1;
        chk("mm_c_hit", {31'd0, ihit}, 32'd1);
        if (ihit) begin
            exp = sb_q.pop_front();
            chk("mm_c_data", imemload, exp);
            exp_hits++;
        end
        tick();
        imemREN = 1'b0;
        fetch(32'h0000_0008, 0, 0);
        fetch(32'h0000_000C, 0, 0);

        // ---- reset asserted in the middle of a miss
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0010;
        tick();
        chk("rm_iren_on", {31'd0, iREN}, 32'd1);
        #2;
        nRST = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
        #1;
        chk("rm_iren_off", {31'd0, iREN}, 32'd0);
        chk("rm_iaddr", iaddr, 32'd0);
        imemREN = 1'b0;
        tick();
        nRST = 1'b1;
        tick();
        fetch(32'h0000_0010, 1, 1);
        fetch(32'h0000_0000, 2, 1);

        // ---- no request while a valid line is present
        imemaddr = 32'h0000_0010;
        imemREN  = 1'b0;
        #2;
        chk("idle_ihit", {31'd0, ihit}, 32'd0);
        chk("idle_imemload", imemload, 32'd0);
        chk("idle_iren", {31'd0, iREN}, 32'd0);
        tick();
        chk("idle_iren_next", {31'd0, iREN}, 32'd0);
        fetch(32'h0000_0010, 0, 0);

`ifdef ICACHE_STATS_EN
        chk("stat_hits_end", hit_count, exp_hits);
        chk("stat_miss_end", miss_count, exp_misses);
`endif
        chk("sb_empty", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule : tb_icache_direct
`default_nettype wire
